// File: rtl/y86_fetch_unit_if.sv
// Bus bundle for the Y86-64 fetch unit: instruction-memory byte port,
// PC-update input and the decoded-instruction output handshake.
interface y86_fetch_unit_if;
  // instruction memory byte read port
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        mem_err;

  // next PC from the PC-update stage
  logic [63:0] new_pc;
  logic        new_pc_valid;

  // decoded instruction towards the rest of the SEQ datapath
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [63:0] pc;
  logic        instr_valid;
  logic        imem_error;

  // fetch unit side
  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata, mem_err,
    input  new_pc, new_pc_valid,
    output out_valid,
    input  out_ready,
    output icode, ifun, rA, rB, valC, valP, pc, instr_valid, imem_error
  );

  // memory / PC-update / consumer side
  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata, mem_err,
    output new_pc, new_pc_valid,
    input  out_valid,
    output out_ready,
    input  icode, ifun, rA, rB, valC, valP, pc, instr_valid, imem_error
  );
endinterface

// File: rtl/y86_fetch_unit.sv
// Byte-serial Y86-64 instruction fetch. Owns the PC, pulls one byte per
// memory handshake, splits the bytes into icode/ifun/rA/rB/valC as they
// arrive, presents the instruction, then waits for the next PC.
module y86_fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  y86_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_PRESENT = 2'd1,
    ST_WAIT_PC = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        req_en_q;           // keeps mem_req low until the first edge after reset
  logic [63:0] pc_q, pc_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  icode_q, icode_d;
  logic [3:0]  ifun_q, ifun_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [63:0] valc_q, valc_d;
  logic [63:0] valp_q, valp_d;
  logic        instr_valid_q, instr_valid_d;
  logic        imem_error_q, imem_error_d;

  logic        mem_req;
  logic [63:0] mem_addr;
  logic        out_valid;
  logic        byte_fire;
  logic        last_byte;
  logic        present_fire;
  logic        must_halt;
  logic [3:0]  cur_len;
  logic [3:0]  valc_idx;

  // Instruction length in bytes, keyed by icode; illegal codes count as 1.
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  // True for instructions carrying an rA:rB byte right after the opcode.
  function automatic logic has_regs(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
      default:                                  has_regs = 1'b0;
    endcase
  endfunction

  // Handshake decode shared by the next-state and datapath logic.
  always_comb begin
    byte_fire    = mem_req & bus.mem_ack;
    // on byte 0 the icode is only available on the bus, not yet in icode_q
    cur_len      = (idx_q == 4'd0) ? instr_len(bus.mem_rdata[7:4]) : instr_len(icode_q);
    last_byte    = ((idx_q + 4'd1) == cur_len);
    valc_idx     = idx_q - (has_regs(icode_q) ? 4'd2 : 4'd1);
    present_fire = out_valid & bus.out_ready;
    must_halt    = (icode_q == 4'h0) | ~instr_valid_q | imem_error_q;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      req_en_q      <= 1'b0;
      pc_q          <= PC_RESET;
      idx_q         <= 4'd0;
      icode_q       <= 4'h0;
      ifun_q        <= 4'h0;
      ra_q          <= 4'hF;
      rb_q          <= 4'hF;
      valc_q        <= 64'h0;
      valp_q        <= 64'h0;
      instr_valid_q <= 1'b1;
      imem_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_en_q      <= 1'b1;
      pc_q          <= pc_d;
      idx_q         <= idx_d;
      icode_q       <= icode_d;
      ifun_q        <= ifun_d;
      ra_q          <= ra_d;
      rb_q          <= rb_d;
      valc_q        <= valc_d;
      valp_q        <= valp_d;
      instr_valid_q <= instr_valid_d;
      imem_error_q  <= imem_error_d;
    end
  end

  // Next-state: fetch until last byte or error, present, then wait or halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   if (byte_fire && (bus.mem_err || last_byte)) state_d = ST_PRESENT;
      ST_PRESENT: if (present_fire) state_d = must_halt ? ST_HALT : ST_WAIT_PC;
      ST_WAIT_PC: if (bus.new_pc_valid) state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_HALT;
    endcase
  end

  // Datapath: place each returned byte into its field; reload on a new PC.
  always_comb begin
    pc_d          = pc_q;
    idx_d         = idx_q;
    icode_d       = icode_q;
    ifun_d        = ifun_q;
    ra_d          = ra_q;
    rb_d          = rb_q;
    valc_d        = valc_q;
    valp_d        = valp_q;
    instr_valid_d = instr_valid_q;
    imem_error_d  = imem_error_q;
    case (state_q)
      ST_FETCH: begin
        if (byte_fire) begin
          if (bus.mem_err) begin
            // keep whatever was assembled so far; the byte itself is dropped
            imem_error_d = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd0) begin
              icode_d       = bus.mem_rdata[7:4];
              ifun_d        = bus.mem_rdata[3:0];
              instr_valid_d = (bus.mem_rdata[7:4] <= 4'hB);
              valp_d        = pc_q + {60'd0, instr_len(bus.mem_rdata[7:4])};
            end else if (has_regs(icode_q) && (idx_q == 4'd1)) begin
              ra_d = bus.mem_rdata[7:4];
              rb_d = bus.mem_rdata[3:0];
            end else begin
              for (int k = 0; k < 8; k++) begin
                if (valc_idx == 4'(k)) valc_d[8*k +: 8] = bus.mem_rdata;
              end
            end
          end
        end
      end
      ST_WAIT_PC: begin
        if (bus.new_pc_valid) begin
          pc_d          = bus.new_pc;
          idx_d         = 4'd0;
          icode_d       = 4'h0;
          ifun_d        = 4'h0;
          ra_d          = 4'hF;
          rb_d          = 4'hF;
          valc_d        = 64'h0;
          valp_d        = 64'h0;
          instr_valid_d = 1'b1;
          imem_error_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs: request while fetching, present while in PRESENT.
  always_comb begin
    mem_req   = req_en_q & (state_q == ST_FETCH);
    mem_addr  = pc_q + {60'd0, idx_q};
    out_valid = (state_q == ST_PRESENT);
  end

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = mem_addr;
  assign bus.out_valid   = out_valid;
  assign bus.icode       = icode_q;
  assign bus.ifun        = ifun_q;
  assign bus.rA          = ra_q;
  assign bus.rB          = rb_q;
  assign bus.valC        = valc_q;
  assign bus.valP        = valp_q;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.imem_error  = imem_error_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Self-checking bench for y86_fetch_unit: byte memory with random wait
// states, and a reference model that decodes instructions straight from
// the memory image using the Y86-64 encoding rules.
module tb_y86_fetch_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  y86_fetch_unit_if bus ();

  y86_fetch_unit #(.PC_RESET(64'h100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        iv;
    logic        ierr;
  } fields_t;

  logic [7:0]  mem [logic [63:0]];
  logic [63:0] err_addr = 64'h0;
  bit          err_en = 1'b0;
  int          wait_min = 0;
  int          wait_max = 0;
  logic [63:0] req_log [$];
  int          unstable_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Write n bytes of v (most significant byte first) starting at address a.
  task automatic write80(input logic [63:0] a, input logic [79:0] v, input int n);
    for (int i = 0; i < n; i++) mem[a + 64'(i)] = v[79-8*i -: 8];
  endtask

  // Reference decode of the instruction at address a; nreq = bytes requested.
  function automatic fields_t model(input logic [63:0] a, output int nreq);
    fields_t    e;
    logic [7:0] b [10];
    int         len, nok, off;
    bit         regs;
    for (int i = 0; i < 10; i++) b[i] = rd(a + 64'(i));
    case (b[0][7:4])
      4'h0, 4'h1, 4'h9:       len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 2;
      4'h7, 4'h8:             len = 9;
      4'h3, 4'h4, 4'h5:       len = 10;
      default:                len = 1;
    endcase
    nok = len;
    for (int i = len - 1; i >= 0; i--)
      if (err_en && ((a + 64'(i)) == err_addr)) nok = i;
    regs = (len == 2) || (len == 10);
    off  = regs ? 2 : 1;
    e = {4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1, 1'b0};
    e.ierr = (nok < len);
    nreq   = e.ierr ? nok + 1 : len;
    if (nok > 0) begin
      e.icode = b[0][7:4];
      e.ifun  = b[0][3:0];
      e.iv    = (b[0][7:4] <= 4'hB);
      e.valp  = a + 64'(len);
    end
    if (regs && nok > 1) begin
      e.ra = b[1][7:4];
      e.rb = b[1][3:0];
    end
    if (len >= 9)
      for (int k = 0; k < 8; k++)
        if (off + k < nok) e.valc[8*k +: 8] = b[off + k];
    return e;
  endfunction

  function automatic fields_t observe();
    return {bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC, bus.valP,
            bus.instr_valid, bus.imem_error};
  endfunction

  function automatic bit addrs_ok(input logic [63:0] a, input int nreq);
    if (req_log.size() != nreq) return 1'b0;
    foreach (req_log[i]) if (req_log[i] !== a + 64'(i)) return 1'b0;
    return 1'b1;
  endfunction

  // Instruction memory: random wait states, tracks address stability.
  initial begin : responder
    bit          pending;
    logic [63:0] pend_addr;
    int          waits_left;
    pending = 1'b0; pend_addr = 64'h0; waits_left = 0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00; bus.mem_err = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_err = 1'b0;
      if (bus.mem_req === 1'b1) begin
        if (!pending) begin
          pending    = 1'b1;
          pend_addr  = bus.mem_addr;
          waits_left = int'($urandom_range(wait_max, wait_min));
        end else if (bus.mem_addr !== pend_addr) begin
          unstable_cnt++;
        end
        if (waits_left == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd(bus.mem_addr);
          bus.mem_err   = err_en && (bus.mem_addr == err_addr);
          req_log.push_back(bus.mem_addr);
          pending = 1'b0;
        end else begin
          waits_left--;
        end
      end else begin
        if (pending && rst_n) unstable_cnt++;
        pending = 1'b0;
      end
    end
  end

  task automatic wait_present(input int budget, output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic accept(input int delay);
    for (int i = 0; i < delay; i++) @(negedge clk);
    $display("accept pc=%h icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h iv=%b err=%b",
             bus.pc, bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC, bus.valP,
             bus.instr_valid, bus.imem_error);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic issue_pc(input logic [63:0] a);
    req_log.delete();
    unstable_cnt = 0;
    bus.new_pc = a;
    bus.new_pc_valid = 1'b1;
    @(negedge clk);
    bus.new_pc_valid = 1'b0;
  endtask

  task automatic start_from_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_log.delete();
    unstable_cnt = 0;
  endtask

  task automatic test_reset();
    fields_t e, g; int nreq, cyc; bit ok;
    write80(64'h100, 80'h30F4EFCDAB8967452301, 10);
    wait_min = 0; wait_max = 0;
    #2 rst_n = 1'b0;
    #2;
    n_vec++;
    if ({bus.mem_req, bus.out_valid} !== 2'b00) begin
      n_err++; $display("FAIL reset_ctrl: got req/valid=%b want 00", {bus.mem_req, bus.out_valid});
    end
    n_vec++;
    if (bus.pc !== 64'h100) begin
      n_err++; $display("FAIL reset_pc: got %h want %h", bus.pc, 64'h100);
    end
    e = {4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1, 1'b0};
    g = observe();
    n_vec++;
    if (g !== e) begin
      n_err++; $display("FAIL reset_fields: got %h want %h", g, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_log.delete();
    wait_present(40, ok, cyc);
    n_vec++;
    if (ok !== 1'b1 || cyc !== 11) begin
      n_err++; $display("FAIL irmovq_latency: got ok=%0b cycles=%0d want ok=1 cycles=11", ok, cyc);
    end
    e = model(64'h100, nreq);
    g = observe();
    n_vec++;
    if (g !== e) begin
      n_err++; $display("FAIL irmovq_fields: got %h want %h", g, e);
    end
    n_vec++;
    if (!addrs_ok(64'h100, nreq)) begin
      n_err++; $display("FAIL irmovq_addrs: got %0d requests want %0d from 100", req_log.size(), nreq);
    end
    accept(0);
  endtask

  task automatic test_jxx_wait();
    fields_t e, g; int nreq, cyc; bit ok; logic [63:0] a;
    a = {$urandom(), $urandom()};
    write80(a, {8'h73, $urandom(), $urandom(), 8'h00}, 9);
    wait_min = 2; wait_max = 2;
    issue_pc(a);
    wait_present(200, ok, cyc);
    n_vec++;
    if (ok !== 1'b1) begin
      n_err++; $display("FAIL jxx_present: got out_valid timeout want out_valid=1");
    end
    e = model(a, nreq);
    g = observe();
    n_vec++;
    if (g !== e) begin
      n_err++; $display("FAIL jxx_fields: got %h want %h", g, e);
    end
    n_vec++;
    if (!addrs_ok(a, nreq) || unstable_cnt != 0) begin
      n_err++; $display("FAIL jxx_addrs: got %0d acks unstable=%0d want %0d acks unstable=0",
                        req_log.size(), unstable_cnt, nreq);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      g = observe();
      n_vec++;
      if (bus.out_valid !== 1'b1 || g !== e) begin
        n_err++; $display("FAIL jxx_hold: got valid=%b %h want valid=1 %h", bus.out_valid, g, e);
      end
    end
    accept(0);
  endtask

  task automatic test_nop_newpc();
    fields_t e, g; int nreq, cyc; bit ok;
    mem[64'h0] = 8'h10;
    write80(64'h40, {8'h61, 8'h23, 64'h0}, 2);
    wait_min = 3; wait_max = 3;
    issue_pc(64'h0);
    // a new PC offered mid-fetch must be ignored
    bus.new_pc = 64'h999;
    bus.new_pc_valid = 1'b1;
    @(negedge clk);
    bus.new_pc_valid = 1'b0;
    wait_present(50, ok, cyc);
    e = model(64'h0, nreq);
    g = observe();
    n_vec++;
    if (ok !== 1'b1 || g !== e) begin
      n_err++; $display("FAIL nop_fields: got ok=%0b %h want ok=1 %h", ok, g, e);
    end
    n_vec++;
    if (bus.pc !== 64'h0 || !addrs_ok(64'h0, nreq)) begin
      n_err++; $display("FAIL nop_pc: got pc=%h reqs=%0d want pc=0 reqs=%0d", bus.pc, req_log.size(), nreq);
    end
    accept(0);
    // new PC arrives in the first WAIT_PC cycle
    issue_pc(64'h40);
    n_vec++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h40) begin
      n_err++; $display("FAIL newpc_req: got req=%b addr=%h want req=1 addr=40", bus.mem_req, bus.mem_addr);
    end
    wait_present(50, ok, cyc);
    e = model(64'h40, nreq);
    g = observe();
    n_vec++;
    if (ok !== 1'b1 || g !== e) begin
      n_err++; $display("FAIL opq_fields: got ok=%0b %h want ok=1 %h", ok, g, e);
    end
    accept(0);
  endtask

  task automatic test_random();
    fields_t e, g; int nreq, cyc; bit ok; logic [63:0] a; logic [79:0] v;
    wait_min = 0; wait_max = 2;
    for (int it = 0; it < 24; it++) begin
      a = {$urandom(), $urandom()};
      v = {$urandom(), $urandom(), 16'($urandom())};
      v[79:76] = 4'($urandom_range(11, 1));
      write80(a, v, 10);
      issue_pc(a);
      wait_present(100, ok, cyc);
      e = model(a, nreq);
      g = observe();
      n_vec++;
      if (ok !== 1'b1 || g !== e) begin
        n_err++; $display("FAIL rand_fields[%0d]: got ok=%0b %h want ok=1 %h", it, ok, g, e);
      end
      n_vec++;
      if (!addrs_ok(a, nreq) || unstable_cnt != 0) begin
        n_err++; $display("FAIL rand_addrs[%0d]: got %0d reqs unstable=%0d want %0d reqs unstable=0",
                          it, req_log.size(), unstable_cnt, nreq);
      end
      accept(int'($urandom_range(3, 0)));
    end
  endtask

  task automatic test_wrap();
    fields_t e, g; int nreq, cyc; bit ok; logic [63:0] a;
    a = 64'hFFFF_FFFF_FFFF_FFFE;
    write80(a, {8'h60, 8'h12, 64'h0}, 2);
    wait_min = 0; wait_max = 0;
    issue_pc(a);
    wait_present(20, ok, cyc);
    e = model(a, nreq);
    g = observe();
    n_vec++;
    if (ok !== 1'b1 || g !== e) begin
      n_err++; $display("FAIL wrap_fields: got ok=%0b %h want ok=1 %h", ok, g, e);
    end
    n_vec++;
    if (!addrs_ok(a, 2) || bus.valP !== 64'h0) begin
      n_err++; $display("FAIL wrap_addrs: got %0d reqs valP=%h want 2 reqs valP=0", req_log.size(), bus.valP);
    end
    accept(0);
  endtask

  task automatic test_halt_cases();
    fields_t e, g; int nreq, cyc, bad; bit ok; logic [7:0] ops [2];
    ops[0] = 8'h00; ops[1] = 8'hC0;
    wait_min = 0; wait_max = 1;
    for (int t = 0; t < 2; t++) begin
      mem[64'h100] = ops[t];
      start_from_reset();
      wait_present(20, ok, cyc);
      e = model(64'h100, nreq);
      g = observe();
      n_vec++;
      if (ok !== 1'b1 || g !== e) begin
        n_err++; $display("FAIL halt_fields[%h]: got ok=%0b %h want ok=1 %h", ops[t], ok, g, e);
      end
      accept(1);
      bad = 0;
      bus.new_pc = 64'h40;
      bus.new_pc_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.mem_req !== 1'b0 || bus.out_valid !== 1'b0) bad++;
      end
      bus.new_pc_valid = 1'b0;
      n_vec++;
      if (bad != 0) begin
        n_err++; $display("FAIL halt_idle[%h]: got %0d active cycles want 0", ops[t], bad);
      end
    end
  endtask

  task automatic test_mem_err();
    fields_t e, g; int nreq, cyc, bad; bit ok;
    write80(64'h100, {8'h40, 8'h12, 64'h1122334455667788}, 10);
    err_en = 1'b1; err_addr = 64'h103;
    wait_min = 0; wait_max = 1;
    start_from_reset();
    wait_present(40, ok, cyc);
    e = model(64'h100, nreq);
    g = observe();
    n_vec++;
    if (ok !== 1'b1 || g !== e) begin
      n_err++; $display("FAIL memerr_fields: got ok=%0b %h want ok=1 %h", ok, g, e);
    end
    n_vec++;
    if (!addrs_ok(64'h100, nreq)) begin
      n_err++; $display("FAIL memerr_addrs: got %0d reqs want %0d", req_log.size(), nreq);
    end
    accept(0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL memerr_idle: got %0d request cycles want 0", bad);
    end
    err_en = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    fields_t e, g; int nreq, cyc; bit ok;
    write80(64'h100, 80'h30F4EFCDAB8967452301, 10);
    wait_min = 0; wait_max = 0;
    start_from_reset();
    repeat (6) @(negedge clk);
    n_vec++;
    if (bus.mem_req !== 1'b1) begin
      n_err++; $display("FAIL midfetch_busy: got req=%b want 1", bus.mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.mem_req !== 1'b0 || bus.valC !== 64'h0 || bus.pc !== 64'h100) begin
      n_err++; $display("FAIL midfetch_reset: got req=%b valC=%h pc=%h want req=0 valC=0 pc=100",
                        bus.mem_req, bus.valC, bus.pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_log.delete();
    wait_present(40, ok, cyc);
    e = model(64'h100, nreq);
    g = observe();
    n_vec++;
    if (ok !== 1'b1 || cyc !== 11 || g !== e) begin
      n_err++; $display("FAIL midfetch_refetch: got ok=%0b cyc=%0d %h want ok=1 cyc=11 %h", ok, cyc, g, e);
    end
    n_vec++;
    if (!addrs_ok(64'h100, nreq)) begin
      n_err++; $display("FAIL midfetch_addrs: got %0d reqs want %0d from 100", req_log.size(), nreq);
    end
    accept(0);
  endtask

  initial begin
    bus.out_ready    = 1'b0;
    bus.new_pc       = 64'h0;
    bus.new_pc_valid = 1'b0;
    test_reset();
    test_jxx_wait();
    test_nop_newpc();
    test_random();
    test_wrap();
    test_halt_cases();
    test_mem_err();
    test_reset_midfetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
